tm_mac: RTL and testbench
=========================

# tm_mac

Time-multiplexed multiply-accumulate stage of the FIR datapath, directly downstream of the coefficient multiplexer. Each cycle it takes one sample, the coefficient selected for the current time slot and the slot counter. It forms the product, accumulates TM products per output frame, and emits one filter partial sum per frame. It also checks that the slot counter steps 0..TM-1 without gaps and flags frames that break this order.

## Interface
- DATAW, 16: sample width, signed
- COEFW, 18: coefficient width, signed
- TM, 2: time-multiplexing factor (products per frame), ≥1
- CW, 1: slot counter width; CW ≥ max(1, $clog2(TM))
- ACCW, 48: accumulator width; must satisfy ACCW ≥ DATAW+COEFW+CW, otherwise wraps two's complement

Ports:
- clk  in  1  single clock, all logic on posedge
- rstn  in  1  synchronous, active-low reset
- valid_in  in  1  slot inputs valid this cycle
- counter_in  in  CW  slot index aligned with coef_in
- coef_in  in  COEFW  signed coefficient for this slot
- data_in  in  DATAW  signed sample for this slot
- err_clr  in  1  clears frame_err
- acc_out  out  ACCW  signed frame sum
- acc_valid  out  1  one-cycle pulse, acc_out holds a new result
- frame_err  out  1  sticky slot-order error flag

## Operation
**Stage 1 (product register):**
- p <= data_in*coef_in, full DATAW+COEFW width, signed.
- v1 <= valid_in; c1 <= counter_in.

**Stage 2 (accumulate).** Acts only when v1=1; v1=0 is a bubble: acc, exp and outputs are held, and acc_valid is 0. Internal state:
- acc, ACCW bits
- exp, CW bits: expected next slot
- drop flag

Slot handling when v1=1:
- c1==0: acc <= sext(p); drop <= 0; exp <= 1. A frame start is always accepted, even mid-frame. An unfinished frame is then discarded and frame_err is set.
- c1==exp, c1≠0: acc <= acc+sext(p); exp <= exp+1.
- c1≥TM or c1≠exp (non-zero): frame_err <= 1; drop <= 1. The product is ignored. exp is held until the next slot 0.
- c1==TM-1 and slot accepted: acc_out <= acc+sext(p) (sext(p) alone when TM=1). acc_valid <= ~drop; exp <= 0.
- TM=1: every valid slot 0 produces a result.

**Error flag:**
- frame_err is cleared by err_clr.
- A new error in the same cycle as err_clr wins, so the flag stays 1.

**Reset** (rstn=0 at a clock edge):
- All registers clear: acc_out=0, acc_valid=0, frame_err=0, acc=0, exp=0, drop=0, v1=0.
- A partial frame in progress is discarded, with no output.

## Timing
- Latency: a last slot (counter_in=TM-1) presented at cycle t gives acc_valid=1 at cycle t+2.
- acc_out stays stable until the next result.
- No backpressure: the block accepts one slot per cycle, always.
- Bubbles may appear anywhere within a frame and only stretch that frame.
- counter_in/coef_in must be presented in the same cycle, as delivered by the upstream multiplexer's registered counter.

## Structure
- Shared package fir_pkg:
  - default widths DATAW/COEFW/ACCW
  - function acc_width(DATAW, COEFW, TM), reused by downstream adders
- One natural sub-module, smul_reg: registered signed multiplier, DSP-inferable, carrying valid and counter alongside.
- Frame checking and accumulation stay in tm_mac.

## Test plan
All scenarios use TM=4, DATAW=16, COEFW=18, ACCW=48 unless stated.
- Full frame, slots 0..3 back-to-back, data {1,2,3,4}, coef {10,20,30,40} -> acc_out=300, acc_valid single pulse 2 cycles after slot 3, frame_err=0.
- Extremes, data=-32768 and coef=-131072 on all 4 slots -> acc_out=17179869184, no wrap.
- Bubbles, same frame as the full-frame case with valid_in=0 for 3 cycles between slots 1 and 2 -> acc_out=300, 2 cycles after slot 3.
- Skipped slot, sequence 0,1,3 then full frame 0..3 with data=1, coef=5 -> first frame: no acc_valid and frame_err=1; second frame: acc_out=20 and frame_err stays 1 until err_clr.
- Reset mid-frame, rstn=0 after slot 1, then full frame of data=2, coef=3 -> all outputs 0 during reset, next acc_out=24, no stale partial sum.
- err_clr collision, err_clr=1 in the cycle an out-of-order slot hits stage 2 -> frame_err remains 1; err_clr alone next cycle -> 0.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared FIR datapath definitions.
//   DATAW_D / COEFW_D / ACCW_D : default sample, coefficient and accumulator widths
//   acc_width()                : minimum accumulator width that cannot wrap when
//                                summing tm products of dataw x coefw signed values
package fir_pkg;

  localparam int DATAW_D = 16;
  localparam int COEFW_D = 18;
  localparam int ACCW_D  = 48;

  // The slot counter is never narrower than one bit, so the growth term
  // has a floor of 1 even when tm is 1.
  function automatic int acc_width(input int dataw, input int coefw, input int tm);
    int growth;
    growth = (tm > 1) ? $clog2(tm) : 1;
    return dataw + coefw + growth;
  endfunction

endpackage

// File: rtl/smul_reg.sv
// Registered signed multiplier with the valid flag and slot counter
// carried alongside, so that the product and its tags stay aligned.
//   clk, rstn        : clock, synchronous active-low reset (tags only)
//   valid_in         : operands valid this cycle
//   counter_in       : slot index tag for the operands
//   a, b             : signed operands
//   p                : registered full-width signed product
//   valid_out        : registered valid_in
//   counter_out      : registered counter_in
module smul_reg #(
  parameter int AW = 16,
  parameter int BW = 18,
  parameter int CW = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 valid_in,
  input  logic [CW-1:0]        counter_in,
  input  logic signed [AW-1:0] a,
  input  logic signed [BW-1:0] b,
  output logic signed [AW+BW-1:0] p,
  output logic                 valid_out,
  output logic [CW-1:0]        counter_out
);

  localparam int PW = AW + BW;

  // The product register carries no reset so it maps onto a DSP output
  // register; downstream only consumes it while valid_out is set.
  always_ff @(posedge clk) begin
    p <= PW'(a) * PW'(b);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_out   <= 1'b0;
      counter_out <= '0;
    end else begin
      valid_out   <= valid_in;
      counter_out <= counter_in;
    end
  end

endmodule

// File: rtl/tm_mac.sv
// Time-multiplexed multiply-accumulate stage of the FIR datapath.
// Stage 1 registers the product of each slot; stage 2 accumulates TM
// products per frame, emits one partial sum per frame and checks that
// the slot counter steps 0..TM-1 without gaps.
//   clk, rstn   : clock, synchronous active-low reset
//   valid_in    : slot inputs valid this cycle
//   counter_in  : slot index aligned with coef_in
//   coef_in     : signed coefficient for this slot
//   data_in     : signed sample for this slot
//   err_clr     : clears frame_err (a simultaneous new error wins)
//   acc_out     : signed frame sum, held until the next result
//   acc_valid   : one-cycle pulse marking a new acc_out
//   frame_err   : sticky slot-order error flag
module tm_mac
  import fir_pkg::*;
#(
  parameter int DATAW = DATAW_D,
  parameter int COEFW = COEFW_D,
  parameter int TM    = 2,
  parameter int CW    = 1,
  parameter int ACCW  = ACCW_D
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    valid_in,
  input  logic [CW-1:0]           counter_in,
  input  logic signed [COEFW-1:0] coef_in,
  input  logic signed [DATAW-1:0] data_in,
  input  logic                    err_clr,
  output logic signed [ACCW-1:0]  acc_out,
  output logic                    acc_valid,
  output logic                    frame_err
);

  localparam int PW = DATAW + COEFW;
  localparam logic [CW:0]   TM_C = (CW + 1)'(TM);
  localparam logic [CW-1:0] LAST = CW'(TM - 1);

  logic signed [PW-1:0] p;
  logic                 v1;
  logic [CW-1:0]        c1;

  smul_reg #(
    .AW(DATAW),
    .BW(COEFW),
    .CW(CW)
  ) u_mul (
    .clk        (clk),
    .rstn       (rstn),
    .valid_in   (valid_in),
    .counter_in (counter_in),
    .a          (data_in),
    .b          (coef_in),
    .p          (p),
    .valid_out  (v1),
    .counter_out(c1)
  );

  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] pext;
  logic signed [ACCW-1:0] acc_sum;
  logic [CW-1:0]          exp_slot;
  logic                   drop;

  logic slot_zero;
  logic in_order;
  logic is_last;
  logic frame_open;
  logic new_err;

  // Sign extension (or two's-complement truncation if ACCW < PW).
  assign pext    = ACCW'(p);
  assign acc_sum = acc + pext;

  always_comb begin
    slot_zero  = (c1 == '0);
    in_order   = !slot_zero && (c1 == exp_slot) && ({1'b0, c1} < TM_C);
    is_last    = (c1 == LAST);
    frame_open = (exp_slot != '0);
    // A slot 0 arriving while a frame is still open discards that frame.
    new_err    = v1 && ((slot_zero && frame_open) || (!slot_zero && !in_order));
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc       <= '0;
      acc_out   <= '0;
      acc_valid <= 1'b0;
      exp_slot  <= '0;
      drop      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      acc_valid <= 1'b0;
      if (v1) begin
        if (slot_zero) begin
          acc  <= pext;
          drop <= 1'b0;
          if (TM == 1) begin
            acc_out   <= pext;
            acc_valid <= 1'b1;
            exp_slot  <= '0;
          end else begin
            exp_slot  <= CW'(1);
          end
        end else if (in_order) begin
          acc <= acc_sum;
          if (is_last) begin
            // A frame that hit a gap still runs to its last slot so exp
            // realigns, but its sum is suppressed.
            acc_out   <= acc_sum;
            acc_valid <= ~drop;
            exp_slot  <= '0;
          end else begin
            exp_slot  <= exp_slot + CW'(1);
          end
        end else begin
          drop <= 1'b1;
        end
      end

      if (new_err)
        frame_err <= 1'b1;
      else if (err_clr)
        frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tm_mac.sv
module tb_tm_mac;

  logic               clk;
  logic               rstn;
  logic               valid_in;
  logic [1:0]         counter_in;
  logic signed [17:0] coef_in;
  logic signed [15:0] data_in;
  logic               err_clr;
  logic signed [47:0] acc_out;
  logic               acc_valid;
  logic               frame_err;

  int n_checks;
  int n_fail;

  tm_mac #(
    .DATAW(16),
    .COEFW(18),
    .TM   (4),
    .CW   (2),
    .ACCW (48)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .valid_in  (valid_in),
    .counter_in(counter_in),
    .coef_in   (coef_in),
    .data_in   (data_in),
    .err_clr   (err_clr),
    .acc_out   (acc_out),
    .acc_valid (acc_valid),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one cycle of inputs, then return 1 ns after the capturing edge.
  task automatic drive(input logic v, input logic [1:0] c,
                       input logic signed [15:0] d, input logic signed [17:0] k);
    valid_in   = v;
    counter_in = c;
    data_in    = d;
    coef_in    = k;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 2'd0, 16'sd0, 18'sd0);
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    err_clr = 1'b0;
    idle(3);
    n_checks++;
    if (acc_out !== 48'sd0) begin n_fail++; $display("FAIL reset_acc_out got %0d want 0", acc_out); end
    n_checks++;
    if (acc_valid !== 1'b0) begin n_fail++; $display("FAIL reset_acc_valid got %b want 0", acc_valid); end
    n_checks++;
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    rstn = 1'b1;
    idle(1);
  endtask

  task automatic test_full_frame;
    drive(1'b1, 2'd0, 16'sd1, 18'sd10);
    drive(1'b1, 2'd1, 16'sd2, 18'sd20);
    drive(1'b1, 2'd2, 16'sd3, 18'sd30);
    drive(1'b1, 2'd3, 16'sd4, 18'sd40);
    valid_in = 1'b0;
    n_checks++;
    if (acc_valid !== 1'b0) begin n_fail++; $display("FAIL full_early_valid got %b want 0", acc_valid); end
    idle(1);
    n_checks++;
    if (acc_valid !== 1'b1) begin n_fail++; $display("FAIL full_valid got %b want 1", acc_valid); end
    n_checks++;
    if (acc_out !== 48'sd300) begin n_fail++; $display("FAIL full_acc_out got %0d want 300", acc_out); end
    n_checks++;
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL full_frame_err got %b want 0", frame_err); end
    idle(1);
    n_checks++;
    if (acc_valid !== 1'b0) begin n_fail++; $display("FAIL full_pulse_width got %b want 0", acc_valid); end
    n_checks++;
    if (acc_out !== 48'sd300) begin n_fail++; $display("FAIL full_hold got %0d want 300", acc_out); end
  endtask

  task automatic test_back_to_back;
    drive(1'b1, 2'd0, 16'sd1, 18'sd1);
    drive(1'b1, 2'd1, 16'sd1, 18'sd2);
    drive(1'b1, 2'd2, 16'sd1, 18'sd3);
    drive(1'b1, 2'd3, 16'sd1, 18'sd4);
    drive(1'b1, 2'd0, -16'sd1, 18'sd5);
    n_checks++;
    if (acc_valid !== 1'b1 || acc_out !== 48'sd10) begin
      n_fail++; $display("FAIL b2b_first got valid=%b acc=%0d want valid=1 acc=10", acc_valid, acc_out);
    end
    drive(1'b1, 2'd1, -16'sd1, 18'sd5);
    n_checks++;
    if (acc_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_gap got %b want 0", acc_valid); end
    drive(1'b1, 2'd2, -16'sd1, 18'sd5);
    drive(1'b1, 2'd3, -16'sd1, 18'sd5);
    idle(1);
    n_checks++;
    if (acc_valid !== 1'b1 || acc_out !== -48'sd20) begin
      n_fail++; $display("FAIL b2b_second got valid=%b acc=%0d want valid=1 acc=-20", acc_valid, acc_out);
    end
    idle(1);
  endtask

  task automatic test_extremes;
    for (int s = 0; s < 4; s++) drive(1'b1, 2'(s), -16'sd32768, -18'sd131072);
    idle(1);
    n_checks++;
    if (acc_valid !== 1'b1 || acc_out !== 48'sd17179869184) begin
      n_fail++; $display("FAIL extremes got valid=%b acc=%0d want valid=1 acc=17179869184", acc_valid, acc_out);
    end
    idle(1);
  endtask

  task automatic test_bubbles;
    drive(1'b1, 2'd0, 16'sd1, 18'sd10);
    drive(1'b1, 2'd1, 16'sd2, 18'sd20);
    idle(3);
    n_checks++;
    if (acc_valid !== 1'b0) begin n_fail++; $display("FAIL bubble_spurious got %b want 0", acc_valid); end
    drive(1'b1, 2'd2, 16'sd3, 18'sd30);
    drive(1'b1, 2'd3, 16'sd4, 18'sd40);
    valid_in = 1'b0;
    n_checks++;
    if (acc_valid !== 1'b0) begin n_fail++; $display("FAIL bubble_early got %b want 0", acc_valid); end
    idle(1);
    n_checks++;
    if (acc_valid !== 1'b1 || acc_out !== 48'sd300) begin
      n_fail++; $display("FAIL bubble_result got valid=%b acc=%0d want valid=1 acc=300", acc_valid, acc_out);
    end
    idle(1);
  endtask

  task automatic test_skipped;
    drive(1'b1, 2'd0, 16'sd1, 18'sd5);
    drive(1'b1, 2'd1, 16'sd1, 18'sd5);
    drive(1'b1, 2'd3, 16'sd1, 18'sd5);
    idle(1);
    n_checks++;
    if (frame_err !== 1'b1) begin n_fail++; $display("FAIL skip_err got %b want 1", frame_err); end
    n_checks++;
    if (acc_valid !== 1'b0) begin n_fail++; $display("FAIL skip_no_result got %b want 0", acc_valid); end
    idle(1);
    n_checks++;
    if (acc_valid !== 1'b0) begin n_fail++; $display("FAIL skip_no_result_late got %b want 0", acc_valid); end
    for (int s = 0; s < 4; s++) drive(1'b1, 2'(s), 16'sd1, 18'sd5);
    idle(1);
    n_checks++;
    if (acc_valid !== 1'b1 || acc_out !== 48'sd20) begin
      n_fail++; $display("FAIL skip_recover got valid=%b acc=%0d want valid=1 acc=20", acc_valid, acc_out);
    end
    n_checks++;
    if (frame_err !== 1'b1) begin n_fail++; $display("FAIL skip_sticky got %b want 1", frame_err); end
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    n_checks++;
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL skip_clear got %b want 0", frame_err); end
  endtask

  task automatic test_reset_mid;
    drive(1'b1, 2'd0, 16'sd7, 18'sd7);
    drive(1'b1, 2'd1, 16'sd7, 18'sd7);
    rstn = 1'b0;
    idle(2);
    n_checks++;
    if (acc_out !== 48'sd0 || acc_valid !== 1'b0 || frame_err !== 1'b0) begin
      n_fail++; $display("FAIL midreset_outputs got acc=%0d valid=%b err=%b want 0 0 0", acc_out, acc_valid, frame_err);
    end
    rstn = 1'b1;
    for (int s = 0; s < 4; s++) drive(1'b1, 2'(s), 16'sd2, 18'sd3);
    idle(1);
    n_checks++;
    if (acc_valid !== 1'b1 || acc_out !== 48'sd24) begin
      n_fail++; $display("FAIL midreset_result got valid=%b acc=%0d want valid=1 acc=24", acc_valid, acc_out);
    end
    n_checks++;
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL midreset_err got %b want 0", frame_err); end
    idle(1);
  endtask

  task automatic test_err_collision;
    n_checks++;
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL coll_pre got %b want 0", frame_err); end
    drive(1'b1, 2'd0, 16'sd1, 18'sd1);
    drive(1'b1, 2'd2, 16'sd1, 18'sd1);
    // The out-of-order slot reaches stage 2 at the next edge, together with err_clr.
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    n_checks++;
    if (frame_err !== 1'b1) begin n_fail++; $display("FAIL coll_set_wins got %b want 1", frame_err); end
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    n_checks++;
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL coll_clear got %b want 0", frame_err); end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rstn       = 1'b0;
    err_clr    = 1'b0;
    valid_in   = 1'b0;
    counter_in = 2'd0;
    data_in    = 16'sd0;
    coef_in    = 18'sd0;
    test_reset();
    test_full_frame();
    test_back_to_back();
    test_extremes();
    test_bubbles();
    test_skipped();
    test_reset_mid();
    test_err_collision();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
